m_led_pulser: RTL and testbench

Output-side companion to the button input filter: turns single-cycle event strobes, such as a filtered button CE pulse, into human-visible LED blinks of fixed on/off length on the same CE timebase. Events that arrive while a blink is in progress are queued in a saturating pending counter and replayed one blink each. The block sits between control logic and a board LED pin.

---
 rtl/m_led_pulser_pkg.sv | 15 +
 rtl/m_led_pulser_evt_sat_cnt.sv | 34 +++
 rtl/m_led_pulser.sv | 109 ++++++++++
 tb/tb_m_led_pulser.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/m_led_pulser_pkg.sv
// Shared front-panel definitions: LED pulser FSM encoding and default tick lengths.
package m_led_pulser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ON   = 2'b01,
    ST_OFF  = 2'b10
  } led_state_t;

  localparam int DEF_ON_TICKS   = 4;
  localparam int DEF_OFF_TICKS  = 4;
  localparam int DEF_CNTR_WIDTH = 4;
  localparam int DEF_PEND_WIDTH = 3;

endpackage

// File: rtl/m_led_pulser_evt_sat_cnt.sv
// Saturating up/down event counter with a sticky overflow flag.
module m_evt_sat_cnt #(
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_nonzero,
  output logic             o_ovf
);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_inc && !i_dec) begin
      // A full counter drops the event and remembers that it did.
      if (&r_count) r_ovf <= 1'b1;
      else          r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_nonzero = (r_count != '0);
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/m_led_pulser.sv
// LED pulser: stretches single-cycle event strobes into CE-timed blinks,
// queueing events that arrive mid-blink and replaying them one blink each.
module m_led_pulser
  import m_led_pulser_pkg::*;
#(
  parameter int ON_TICKS   = DEF_ON_TICKS,
  parameter int OFF_TICKS  = DEF_OFF_TICKS,
  parameter int CNTR_WIDTH = DEF_CNTR_WIDTH,
  parameter int PEND_WIDTH = DEF_PEND_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  EVT_IN,
  output logic                  LED_OUT,
  output logic                  BUSY,
  output logic [PEND_WIDTH-1:0] PEND_CNT,
  output logic                  OVF
);

  localparam logic [CNTR_WIDTH-1:0] ON_LAST  = CNTR_WIDTH'(ON_TICKS - 1);
  localparam logic [CNTR_WIDTH-1:0] OFF_LAST = CNTR_WIDTH'(OFF_TICKS - 1);

  led_state_t            r_state;
  logic [CNTR_WIDTH-1:0] r_timer;
  logic                  r_led;
  logic                  r_busy;

  logic                  w_idle;
  logic                  w_nonzero;
  logic                  w_deq;
  logic                  w_direct;
  logic                  w_enq;
  logic [PEND_WIDTH-1:0] w_count;
  logic                  w_ovf;

  // Queued events take priority; a fresh event is consumed directly only when
  // nothing is waiting, otherwise it joins the queue.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_deq    = w_idle && w_nonzero;
  assign w_direct = w_idle && !w_nonzero && EVT_IN;
  assign w_enq    = EVT_IN && !w_direct;

  m_evt_sat_cnt #(
    .WIDTH(PEND_WIDTH)
  ) u_pend (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_inc     (w_enq),
    .i_dec     (w_deq),
    .o_count   (w_count),
    .o_nonzero (w_nonzero),
    .o_ovf     (w_ovf)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_nonzero || EVT_IN) begin
            r_state <= ST_ON;
            r_timer <= '0;
            r_led   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_ON: begin
          if (CE) begin
            if (r_timer == ON_LAST) begin
              r_state <= ST_OFF;
              r_timer <= '0;
              r_led   <= 1'b0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        ST_OFF: begin
          if (CE) begin
            if (r_timer == OFF_LAST) begin
              r_state <= ST_IDLE;
              r_timer <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_timer <= '0;
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign LED_OUT  = r_led;
  assign BUSY     = r_busy;
  assign PEND_CNT = w_count;
  assign OVF      = w_ovf;

endmodule

// File: tb/tb_m_led_pulser.sv
// Bench for m_led_pulser: countdown-based blink model checked every cycle,
// plus directed scenarios with hand-computed blink timing.
module tb_m_led_pulser;

  localparam int ON   = 3;
  localparam int OFF  = 2;
  localparam int CW   = 4;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce  = 1'b1;
  logic          evt = 1'b0;
  logic          led;
  logic          busy;
  logic          ovf;
  logic [PW-1:0] pend;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  m_led_pulser #(
    .ON_TICKS   (ON),
    .OFF_TICKS  (OFF),
    .CNTR_WIDTH (CW),
    .PEND_WIDTH (PW)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .CE       (ce),
    .EVT_IN   (evt),
    .LED_OUT  (led),
    .BUSY     (busy),
    .PEND_CNT (pend),
    .OVF      (ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Blink model: a blink is "lit for ON CE ticks, then dark for OFF CE ticks",
  // tracked as a countdown of remaining ticks; the queue is a bounded integer.
  int m_pend  = 0;
  bit m_ovf   = 0;
  bit m_busy  = 0;
  bit m_lit   = 0;
  int m_left  = 0;
  bit m_valid = 0;

  always @(posedge clk) begin : model
    int p, left;
    bit o, b, l, deq, direct, enq;
    p = m_pend; o = m_ovf; b = m_busy; l = m_lit; left = m_left;
    if (rst) begin
      p = 0; o = 0; b = 0; l = 0; left = 0;
    end else begin
      deq = 0; direct = 0;
      if (!b) begin
        if (p > 0) deq = 1;
        else if (evt) direct = 1;
        if (deq || direct) begin
          b = 1; l = 1; left = ON;
        end
      end else if (ce) begin
        left = left - 1;
        if (left == 0) begin
          if (l) begin
            l = 0; left = OFF;
          end else begin
            b = 0;
          end
        end
      end
      enq = evt && !direct;
      if (enq && !deq) begin
        if (p == PMAX) o = 1;
        else p = p + 1;
      end else if (deq && !enq) begin
        p = p - 1;
      end
    end
    m_pend  <= p;
    m_ovf   <= o;
    m_busy  <= b;
    m_lit   <= l;
    m_left  <= left;
    if (rst) m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("LED_OUT",  32'(led),  32'(m_lit));
      chk("BUSY",     32'(busy), 32'(m_busy));
      chk("PEND_CNT", 32'(pend), 32'(m_pend));
      chk("OVF",      32'(ovf),  32'(m_ovf));
    end
  end

  task automatic step(input bit r, input bit e, input bit c);
    rst = r; evt = e; ce = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1, 0, 1);
    step(0, 0, 1);
  endtask

  initial begin
    int lit, bsy, pmax, prev, nrise, ph, offc;
    int rises[$];

    // Reset held with EVT_IN toggling
    for (int k = 0; k < 3; k++) begin
      step(1, k[0], 1);
      chk("rst_led", 32'(led), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pend", 32'(pend), 0);
      chk("rst_ovf", 32'(ovf), 0);
    end
    step(0, 0, 1);
    chk("rst_release_pend", 32'(pend), 0);

    // Single event
    lit = 0; bsy = 0; pmax = 0;
    for (int k = 0; k < 12; k++) begin
      step(0, k == 0, 1);
      if (k == 0) chk("s2_latency", 32'(led), 1);
      lit += int'(led); bsy += int'(busy);
      if (int'(pend) > pmax) pmax = int'(pend);
    end
    chk("s2_lit_clocks", lit, 3);
    chk("s2_busy_clocks", bsy, 5);
    chk("s2_pend_max", pmax, 0);

    // Three consecutive events
    lit = 0; pmax = 0; prev = 0; rises.delete();
    for (int k = 0; k < 25; k++) begin
      step(0, k < 3, 1);
      if (k == 1) chk("s3_pend_after_2nd", 32'(pend), 1);
      if (k == 2) chk("s3_pend_after_3rd", 32'(pend), 2);
      if (led && prev == 0) rises.push_back(k);
      prev = int'(led); lit += int'(led);
      if (int'(pend) > pmax) pmax = int'(pend);
    end
    chk("s3_blinks", rises.size(), 3);
    chk("s3_lit_clocks", lit, 9);
    chk("s3_pend_max", pmax, 2);
    chk("s3_pend_end", 32'(pend), 0);
    if (rises.size() == 3) begin
      chk("s3_first_start", rises[0], 0);
      chk("s3_spacing1", rises[1] - rises[0], 6);
      chk("s3_spacing2", rises[2] - rises[1], 6);
    end

    // Saturation: one direct event then five more during the first blink
    pmax = 0; prev = 0; nrise = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, k < 6, 1);
      if (led && prev == 0) nrise++;
      prev = int'(led);
      if (int'(pend) > pmax) pmax = int'(pend);
    end
    chk("s4_blinks", nrise, 4);
    chk("s4_pend_max", pmax, 3);
    chk("s4_ovf_sticky", 32'(ovf), 1);
    chk("s4_pend_end", 32'(pend), 0);
    step(1, 0, 1);
    chk("s4_ovf_cleared", 32'(ovf), 0);
    step(0, 0, 1);

    // CE on every 4th clock, random phase of the event relative to CE
    ph = $urandom_range(0, 3);
    lit = 0; offc = 0;
    for (int k = 0; k < 60; k++) begin
      step(0, k == ph, (k % 4) == 0);
      lit += int'(led);
      offc += int'(busy && !led);
    end
    chk("s5_lit_in_range", 32'(lit >= 9 && lit <= 12), 1);
    chk("s5_dark_in_range", 32'(offc >= 6 && offc <= 8), 1);
    chk("s5_idle_end", 32'(busy), 0);

    // Reset in the second lit clock of a queued blink with two still pending
    for (int k = 0; k < 8; k++) step(0, k < 4, 1);
    chk("s6_pre_led", 32'(led), 1);
    chk("s6_pre_pend", 32'(pend), 2);
    step(1, 0, 1);
    chk("s6_led", 32'(led), 0);
    chk("s6_pend", 32'(pend), 0);
    chk("s6_busy", 32'(busy), 0);
    lit = 0;
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 1);
      lit += int'(led);
    end
    chk("s6_no_blinks", lit, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 2500; k++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
